// File: rtl/pipe_pkg.sv
// Shared defaults and width helpers for the pipeline buffer.
// Pointers are log2(depth) bits wide; the occupancy count needs one more bit.
package pipe_pkg;

    localparam int PIPE_WIDTH = 32;
    localparam int PIPE_DEPTH = 4;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pipe_fifo_ptr.sv
// Wrapping buffer pointer with synchronous clear and increment enable.
// Wraps naturally because the depth is a power of two.
module pipe_fifo_ptr
    import pipe_pkg::*;
#(
    parameter  int DEPTH = PIPE_DEPTH,
    localparam int PW    = ptr_bits(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/pipe_fifo.sv
// Valid/ready pipeline buffer. All outputs decode from registered state,
// so the consumer's ready never reaches the producer combinationally.
module pipe_fifo
    import pipe_pkg::*;
#(
    parameter  int WIDTH = PIPE_WIDTH,
    parameter  int DEPTH = PIPE_DEPTH,
    localparam int PW    = ptr_bits(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    pipe_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    pipe_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Flush leaves storage intact; only the pointers and count are discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_fifo.sv
// Self-checking bench for pipe_fifo: directed scenarios plus a randomised
// run against a queue model of the buffer's occupancy and ordering.
module tb_pipe_fifo;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] model [$];
    bit           stall_pend = 1'b0;
    logic [W-1:0] stall_data = '0;

    pipe_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Advance one clock; update the model from the rules and check protocol.
    task automatic tick();
        bit do_push, do_pop, prev_ov, prev_or, prev_fl;
        if (reset && stall_pend && in_valid) begin
            assert (in_data === stall_data) else begin
                mismatched++;
                $display("FAIL in_data_hold got %h want %h", in_data, stall_data);
            end
        end
        prev_ov    = out_valid;
        prev_or    = out_ready;
        prev_fl    = flush;
        do_push    = in_valid && (model.size() < D);
        do_pop     = out_ready && (model.size() > 0);
        stall_pend = in_valid && !in_ready;
        stall_data = in_data;
        @(posedge clk);
        if (!reset || flush) begin
            model.delete();
        end else begin
            if (do_pop) void'(model.pop_front());
            if (do_push) model.push_back(in_data);
        end
        #1;
        if (reset && prev_ov && !prev_or && !prev_fl) begin
            compared++;
            assert (out_valid === 1'b1) else begin
                mismatched++;
                $display("FAIL out_valid_hold got %b want 1", out_valid);
            end
        end
    endtask

    task automatic do_flush();
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0 || out_data !== '0) begin
            mismatched++;
            $display("FAIL reset_state got v=%b r=%b c=%0d d=%h want v=0 r=1 c=0 d=0",
                     out_valid, in_ready, count, out_data);
        end
        #10 reset = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            tick();
        end
        in_valid = 1'b0;
        compared++;
        if (count !== CW'(3)) begin
            mismatched++;
            $display("FAIL pre_reset_count got %0d want 3", count);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL async_reset got v=%b c=%0d r=%b want v=0 c=0 r=1",
                     out_valid, count, in_ready);
        end
        #3 reset = 1'b1;
        model.delete();
        stall_pend = 1'b0;
        in_valid = 1'b1; in_data = 32'hA5;
        tick();
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5) begin
            mismatched++;
            $display("FAIL push_after_reset got v=%b d=%h want v=1 d=a5", out_valid, out_data);
        end
    endtask

    task automatic test_full();
        logic [W-1:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [W-1:0] rest [3] = '{32'h22, 32'h33, 32'h44};
        do_flush();
        in_valid = 1'b1;
        foreach (vals[i]) begin
            in_data = vals[i];
            tick();
        end
        compared++;
        if (count !== CW'(4) || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL full_state got c=%0d r=%b want c=4 r=0", count, in_ready);
        end
        in_data = 32'h55; out_ready = 1'b1;
        compared++;
        if (out_data !== 32'h11) begin
            mismatched++;
            $display("FAIL full_head got %h want 11", out_data);
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        compared++;
        if (count !== CW'(3) || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL full_pop got c=%0d r=%b want c=3 r=1", count, in_ready);
        end
        out_ready = 1'b1;
        foreach (rest[i]) begin
            compared++;
            if (out_valid !== 1'b1 || out_data !== rest[i]) begin
                mismatched++;
                $display("FAIL full_drain got v=%b d=%h want v=1 d=%h", out_valid, out_data, rest[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || count !== '0) begin
            mismatched++;
            $display("FAIL full_empty got v=%b c=%0d want v=0 c=0 (55 must not enter)", out_valid, count);
        end
    endtask

    task automatic test_stream();
        do_flush();
        in_valid = 1'b1; in_data = 0; out_ready = 1'b1;
        tick();
        for (int i = 1; i < 10; i++) begin
            in_data = W'(i);
            compared++;
            if (out_valid !== 1'b1 || out_data !== W'(i - 1) || count !== CW'(1)) begin
                mismatched++;
                $display("FAIL stream got v=%b d=%0d c=%0d want v=1 d=%0d c=1",
                         out_valid, out_data, count, i - 1);
            end
            tick();
        end
        in_valid = 1'b0;
        compared++;
        if (out_data !== W'(9)) begin
            mismatched++;
            $display("FAIL stream_last got %0d want 9", out_data);
        end
        tick();
        out_ready = 1'b0;
        compared++;
        if (count !== '0) begin
            mismatched++;
            $display("FAIL stream_drain got %0d want 0", count);
        end
    endtask

    task automatic test_back_to_back();
        do_flush();
        in_valid = 1'b1;
        in_data = 32'hAA; tick();
        in_data = 32'hBB; tick();
        in_data = 32'hCC; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        compared++;
        if (count !== CW'(2) || out_data !== 32'hBB) begin
            mismatched++;
            $display("FAIL simul got c=%0d d=%h want c=2 d=bb", count, out_data);
        end
        tick();
        compared++;
        if (count !== CW'(1) || out_data !== 32'hCC) begin
            mismatched++;
            $display("FAIL simul_tail got c=%0d d=%h want c=1 d=cc", count, out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_flush();
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = W'(i);
            tick();
        end
        flush = 1'b1; in_data = 32'h77; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        compared++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL flush got c=%0d v=%b r=%b want c=0 v=0 r=1", count, out_valid, in_ready);
        end
        in_valid = 1'b1; in_data = 32'h88;
        tick();
        in_valid = 1'b0;
        compared++;
        if (count !== CW'(1) || out_data !== 32'h88) begin
            mismatched++;
            $display("FAIL flush_after got c=%0d d=%h want c=1 d=88", count, out_data);
        end
    endtask

    task automatic test_random();
        bit keep = 1'b0;
        do_flush();
        for (int i = 0; i < 2000; i++) begin
            if (!keep) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            if (out_ready && !flush && model.size() > 0) begin
                compared++;
                if (out_data !== model[0]) begin
                    mismatched++;
                    $display("FAIL rand_data cyc %0d got %h want %h", i, out_data, model[0]);
                end
            end
            keep = in_valid && (model.size() == D);
            tick();
            compared++;
            if (count !== CW'(model.size()) || count > CW'(D) ||
                out_valid !== (model.size() != 0) || in_ready !== (model.size() != D)) begin
                mismatched++;
                $display("FAIL rand_state cyc %0d got c=%0d v=%b r=%b want c=%0d",
                         i, count, out_valid, in_ready, model.size());
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full();
        test_stream();
        test_back_to_back();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_fifo.md
Name: pipe_fifo

Overview:
- Parameterised valid/ready buffer that sits between two pipeline stages. It is the consuming end of a stage register.
- The upstream stage writes entries into it. The downstream stage reads them out in order and can apply backpressure.
- Absorbs stalls without a combinational ready path from the consumer back to the producer.
- Used between fetch/decode and in front of the memory-response path.

Parameters:
WIDTH, 32, payload width in bits.
DEPTH, 4, number of entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
flush  input  1  synchronous discard of all entries (pipeline redirect).
in_valid  input  1  upstream presents in_data.
in_ready  output  1  buffer can accept an entry this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  head entry available.
out_ready  input  1  downstream accepts head this cycle.
out_data  output  WIDTH  head entry payload.
count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- While reset is low:
  - wr_ptr = rd_ptr = 0, count = 0, storage = 0.
  - Therefore out_valid = 0, out_data = 0, in_ready = 1.
- Push: occurs when in_valid && in_ready at the rising edge.
  - in_data is written to mem[wr_ptr].
  - wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready at the rising edge.
  - rd_ptr increments modulo DEPTH.
- Output decode (all from registered state, no combinational input-to-output paths):
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr].
- Latency: an entry pushed at edge N appears on out_data with out_valid = 1 after edge N, so it is consumable at edge N+1. There is no same-cycle pass-through.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full (count = DEPTH):
  - in_ready = 0, even when out_ready = 1 in the same cycle.
  - A pop that cycle makes in_ready = 1 on the next cycle.
- Empty (count = 0):
  - out_valid = 0 and out_data is don't-care; it holds the stale value, not cleared.
  - out_ready is ignored.
- Pointer wrap: the pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is determined solely by count.
- Ordering: strict FIFO. No entry is ever duplicated or dropped except by flush or reset.
- Flush (synchronous, highest priority after reset):
  - At the edge with flush = 1: wr_ptr, rd_ptr and count all go to 0.
  - A push or pop presented in that same cycle has no effect; the push is dropped.
  - Storage is not cleared.
  - The next cycle shows out_valid = 0 and in_ready = 1.
- Reset mid-operation: clears state asynchronously regardless of clk. Outputs reach their reset values without waiting for an edge.
- Protocol assumptions the bench must assert:
  - in_data is held stable while in_valid && !in_ready.
  - Once out_valid rises, it stays high until a pop or a flush.

Decomposition:
- Package pipe_pkg holds:
  - default constants PIPE_WIDTH = 32 and PIPE_DEPTH = 4;
  - a localparam function for the pointer and count widths.
- One sub-module, pipe_fifo_ptr:
  - a wrapping pointer register with async active-low reset, synchronous clear and an increment enable;
  - instantiated twice, for the write and read pointers.
- The count register and storage array live in pipe_fifo.

Test Plan:
- Reset low mid-stream with count = 3 -> out_valid = 0, count = 0, in_ready = 1 immediately, before any clk edge. After release, push 0xA5 -> out_data = 0xA5 one cycle later.
- out_ready = 0, push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count = 4 and in_ready = 0. Then hold in_valid with 0x55 and out_ready = 1 for one cycle -> 0x11 pops, 0x55 is not accepted, and next cycle in_ready = 1 and count = 3.
- Continuous push and pop of 0..9 with DEPTH = 4 -> outputs appear in order 0..9. Count stays at 1 after the first push. Pointers wrap at least twice.
- Simultaneous push and pop at count = 2 -> count stays at 2. Head advances to the next entry. The new entry lands at the tail.
- Flush asserted with count = 3 alongside in_valid = 1 (0x77) and out_ready = 1 -> next cycle count = 0 and out_valid = 0. 0x77 is never output, and no entry pops that cycle.
- Randomised valid/ready over 2000 cycles with a scoreboard -> no loss, duplication or reordering. Count always equals pushes minus pops, bounded 0..DEPTH.
